// File: rtl/led_sequence_ctrl.sv
// MMIO-programmed LED blink sequencer: steps through a period/mask/duration table on a prescaled tick.
// Optional interrupt output and CTRL irq_en bit are built when LED_SEQ_IRQ_EN is defined.
module led_sequence_ctrl #(
    parameter int W        = 4,
    parameter int CNT_W    = 16,
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 read,
    input  logic                 write,
    input  logic [4:0]           addr,
    input  logic [31:0]          wr_data,
    output logic [31:0]          rd_data,
    output logic [W*CNT_W-1:0]   period_out,
    output logic                 period_vld,
    output logic                 busy
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [4:0]      DEPTH_C = 5'(DEPTH);
    localparam logic [PS_W-1:0] PS_MAX  = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_table [DEPTH];
    logic [4:0]           r_nstep;
    logic                 r_loop_en;
    logic                 r_done;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_dur;
    logic [PS_W-1:0]      r_presc;
    logic [W*CNT_W-1:0]   r_period;
    logic                 r_vld;
    logic                 r_busy;
    logic                 w_irq_en_rd;

    logic                 w_wr;
    logic                 w_ctrl_wr;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_done_clr;
    logic                 w_start_acc;
    logic                 w_step_wr;
    logic                 w_step_hit;
    logic [31:0]          w_entry;
    logic                 w_tick;
    logic                 w_expire;
    logic                 w_more;
    logic                 w_do_load;
    logic                 w_do_clear;
    logic                 w_set_done;
    logic [W*CNT_W-1:0]   w_period_load;
    logic [3:0]           w_cur_idx;
    logic                 w_unused_rd;

    assign w_unused_rd = read;

    assign w_wr        = cs & write;
    assign w_ctrl_wr   = w_wr & (addr == 5'd0);
    assign w_start     = w_ctrl_wr & wr_data[0];
    assign w_stop      = w_ctrl_wr & wr_data[1];
    assign w_done_clr  = w_ctrl_wr & wr_data[3];
    // A start with an empty table is dropped; stop always beats start.
    assign w_start_acc = w_start & ~w_stop & (r_nstep != 5'd0);
    assign w_step_hit  = addr[4] & ({1'b0, addr[3:0]} < DEPTH_C);
    assign w_step_wr   = w_wr & w_step_hit;
    assign w_entry     = r_table[r_idx];
    assign w_tick      = (r_state == S_RUN) && (r_presc == PS_MAX);
    // Duration 0 never expires, so the step holds until stop or start.
    assign w_expire    = w_tick && (r_dur == 8'd1);
    assign w_more      = (5'(r_idx) + 5'd1) < r_nstep;
    assign w_cur_idx   = 4'(r_idx);

    assign period_out  = r_period;
    assign period_vld  = r_vld;
    assign busy        = r_busy;

`ifdef LED_SEQ_IRQ_EN
    logic r_irq_en;
    assign w_irq_en_rd = r_irq_en;
    assign irq         = r_done & r_irq_en;
`else
    assign w_irq_en_rd = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start_acc) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_LOAD:  w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_expire) begin
                        w_state_nxt = (w_more || r_loop_en) ? S_LOAD : S_FIN;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_FIN:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: which datapath action the current state requests
    always_comb begin
        w_do_load  = 1'b0;
        w_do_clear = 1'b0;
        w_set_done = 1'b0;
        if (w_stop) begin
            w_do_clear = 1'b1;
        end else if (w_start_acc) begin
            w_do_load = (r_state == S_LOAD);
        end else begin
            case (r_state)
                S_LOAD: w_do_load = 1'b1;
                S_FIN: begin
                    w_do_clear = 1'b1;
                    w_set_done = 1'b1;
                end
                default: w_do_load = 1'b0;
            endcase
        end
    end

    // Expand the current step entry into per-LED periods
    always_comb begin
        w_period_load = {(W*CNT_W){1'b0}};
        for (int i = 0; i < W; i++) begin
            w_period_load[i*CNT_W +: CNT_W] = w_entry[16+i] ? w_entry[CNT_W-1:0] : {CNT_W{1'b0}};
        end
    end

    // Sequencer datapath: step index, duration/prescaler counters, LED outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= {IDX_W{1'b0}};
            r_dur    <= 8'd0;
            r_presc  <= {PS_W{1'b0}};
            r_period <= {(W*CNT_W){1'b0}};
            r_vld    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_stop) begin
                r_idx <= r_idx;
            end else if (w_start_acc) begin
                r_idx <= {IDX_W{1'b0}};
            end else if (w_expire && w_more) begin
                r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            end else if (w_expire && r_loop_en) begin
                r_idx <= {IDX_W{1'b0}};
            end else begin
                r_idx <= r_idx;
            end
            if (w_do_load) begin
                r_dur   <= w_entry[31:24];
                r_presc <= {PS_W{1'b0}};
            end else if (r_state == S_RUN) begin
                r_presc <= w_tick ? {PS_W{1'b0}} : r_presc + {{(PS_W-1){1'b0}}, 1'b1};
                if (w_tick && (r_dur != 8'd0)) begin
                    r_dur <= r_dur - 8'd1;
                end else begin
                    r_dur <= r_dur;
                end
            end else begin
                r_dur   <= r_dur;
                r_presc <= r_presc;
            end
            if (w_do_load) begin
                r_period <= w_period_load;
                r_vld    <= 1'b1;
            end else if (w_do_clear) begin
                r_period <= {(W*CNT_W){1'b0}};
                r_vld    <= 1'b1;
            end else begin
                r_vld    <= 1'b0;
            end
        end
    end

    // Software-visible registers and step table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_table[k] <= 32'd0;
            end
            r_nstep   <= 5'd0;
            r_loop_en <= 1'b0;
            r_done    <= 1'b0;
`ifdef LED_SEQ_IRQ_EN
            r_irq_en  <= 1'b0;
`endif
        end else begin
            if (w_step_wr) begin
                r_table[addr[IDX_W-1:0]] <= wr_data;
            end
            if (w_wr && (addr == 5'd1)) begin
                r_nstep <= (wr_data[4:0] > DEPTH_C) ? DEPTH_C : wr_data[4:0];
            end
            if (w_ctrl_wr) begin
                r_loop_en <= wr_data[2];
`ifdef LED_SEQ_IRQ_EN
                r_irq_en  <= wr_data[4];
`endif
            end
            // A completion in the same cycle as done_clr keeps done set.
            if (w_set_done) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end else begin
                r_done <= r_done;
            end
        end
    end

    // Read-back mux
    always_comb begin
        rd_data = 32'd0;
        if (addr == 5'd0) begin
            rd_data = {27'd0, w_irq_en_rd, 1'b0, r_loop_en, 2'b00};
        end else if (addr == 5'd1) begin
            rd_data = {27'd0, r_nstep};
        end else if (addr == 5'd2) begin
            rd_data = {20'd0, w_cur_idx, 6'd0, r_done, r_busy};
        end else if (w_step_hit) begin
            rd_data = r_table[addr[IDX_W-1:0]];
        end else begin
            rd_data = 32'd0;
        end
    end

endmodule
